// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register and its frame counter.
package usr_pkg;

  // Operating modes selected by the 2-bit mode input.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Direction of the most recent shift, used to detect direction changes.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Maps a shifting mode onto the direction it moves data.
  function automatic logic shift_dir(input logic [1:0] m);
    return (m == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift_frame_counter.sv
// Counts consecutive same-direction shifts and flags each completed frame.
module shift_frame_counter
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_done;

  logic [CNT_W-1:0] w_cntNext;
  logic             w_dirNext;
  logic             w_doneNext;
  logic             w_dirReq;
  logic [CNT_W-1:0] w_run;

  // Next-state logic: unknown modes fall through to the hold default.
  always_comb begin
    w_cntNext  = r_cnt;
    w_dirNext  = r_dir;
    w_doneNext = 1'b0;
    w_dirReq   = r_dir;
    w_run      = r_cnt;
    if (en) begin
      case (mode)
        MODE_SHR, MODE_SHL: begin
          w_dirReq  = shift_dir(mode);
          w_run     = (w_dirReq == r_dir) ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
          w_dirNext = w_dirReq;
          if (w_run == CNT_W'(WIDTH)) begin
            w_cntNext  = '0;
            w_doneNext = 1'b1;
          end else begin
            w_cntNext = w_run;
          end
        end
        MODE_LOAD: begin
          w_cntNext = '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Counter state with asynchronous clear; last direction resets to right.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt  <= '0;
      r_dir  <= DIR_RIGHT;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cntNext;
      r_dir  <= w_dirNext;
      r_done <= w_doneNext;
    end
  end

  assign shift_cnt  = r_cnt;
  assign frame_done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift right/left, parallel load,
// with frame tracking for assembling serial bits into parallel words.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_qNext;

  // Data path mux: an unknown mode keeps the current contents.
  always_comb begin
    w_qNext = r_q;
    if (en) begin
      case (mode)
        MODE_HOLD: w_qNext = r_q;
        MODE_SHR:  w_qNext = {ser_in_r, r_q[WIDTH-1:1]};
        MODE_SHL:  w_qNext = {r_q[WIDTH-2:0], ser_in_l};
        MODE_LOAD: w_qNext = par_in;
        default:   w_qNext = r_q;
      endcase
    end
  end

  // Data register with asynchronous clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q <= '0;
    end else begin
      r_q <= w_qNext;
    end
  end

  shift_frame_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_frame (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .mode      (mode),
    .shift_cnt (shift_cnt),
    .frame_done(frame_done)
  );

  assign q_out     = r_q;
  assign ser_out_r = r_q[0];
  assign ser_out_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: frame-queue reference model, per-cycle compare,
// directed literal checks and randomized stimulus.
module tb_univ_shift_reg;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          clr;
  logic          en;
  logic [1:0]    mode;
  logic          ser_in_r;
  logic          ser_in_l;
  logic [W-1:0]  par_in;
  logic [W-1:0]  q_out;
  logic          ser_out_r;
  logic          ser_out_l;
  logic [CW-1:0] shift_cnt;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;
  bit cmpOn    = 0;

  logic [W-1:0] mQ = '0;
  logic         mDone = 1'b0;
  logic         frameDirs[$];

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .mode      (mode),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .par_in    (par_in),
    .q_out     (q_out),
    .ser_out_r (ser_out_r),
    .ser_out_l (ser_out_l),
    .shift_cnt (shift_cnt),
    .frame_done(frame_done)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Records one shift in the frame: a direction change starts a fresh frame,
  // and reaching W shifts completes it.
  task automatic countShift(input logic d);
    if (frameDirs.size() > 0 && frameDirs[$] != d) frameDirs.delete();
    frameDirs.push_back(d);
    if (frameDirs.size() == W) begin
      mDone = 1'b1;
      frameDirs.delete();
    end
  endtask

  // Reference model update for one rising edge using the stable inputs.
  task automatic modelStep();
    mDone = 1'b0;
    if (clr !== 1'b1) begin
      mQ = '0;
      frameDirs.delete();
    end else if (en === 1'b1) begin
      if (mode === 2'b01) begin
        mQ = (mQ >> 1) | (W'(ser_in_r) << (W - 1));
        countShift(1'b0);
      end else if (mode === 2'b10) begin
        mQ = (mQ << 1) | W'(ser_in_l);
        countShift(1'b1);
      end else if (mode === 2'b11) begin
        mQ = par_in;
        frameDirs.delete();
      end
    end
  endtask

  always @(posedge clk) modelStep();

  // Asynchronous clear reaches the model immediately too.
  always @(negedge clr) begin
    mQ    = '0;
    mDone = 1'b0;
    frameDirs.delete();
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("q_out",      32'(q_out),      32'(mQ));
      checkOutput("ser_out_r",  32'(ser_out_r),  32'(mQ[0]));
      checkOutput("ser_out_l",  32'(ser_out_l),  32'(mQ[W-1]));
      checkOutput("shift_cnt",  32'(shift_cnt),  32'(frameDirs.size()));
      checkOutput("frame_done", 32'(frame_done), 32'(mDone));
    end
  end

  // Drives one cycle of inputs and returns just after the following falling edge.
  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic sr,
                               input logic sl, input logic [W-1:0] p);
    en       = e;
    mode     = m;
    ser_in_r = sr;
    ser_in_l = sl;
    par_in   = p;
    @(negedge clk);
    #1;
  endtask

  // Drops clr between edges and checks the immediate clear.
  task automatic asyncClear();
    #2;
    clr = 1'b0;
    #1;
    checkOutput("clr_q",    32'(q_out),      32'h0);
    checkOutput("clr_cnt",  32'(shift_cnt),  32'h0);
    checkOutput("clr_done", 32'(frame_done), 32'h0);
  endtask

  logic [W-1:0] rightQ[4];
  logic [W-1:0] bitsR;

  initial begin
    clr = 1'b0; en = 1'b0; mode = 2'b00;
    ser_in_r = 1'b0; ser_in_l = 1'b0; par_in = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_q",    32'(q_out),      32'h0);
    checkOutput("reset_cnt",  32'(shift_cnt),  32'h0);
    checkOutput("reset_done", 32'(frame_done), 32'h0);
    cmpOn = 1;
    clr   = 1'b1;

    // Load 1010, clear mid-cycle, hold clear across two edges.
    applyStimulus(1, 2'b11, 0, 0, 4'b1010);
    checkOutput("load_1010", 32'(q_out), 32'hA);
    asyncClear();
    applyStimulus(1, 2'b11, 0, 0, 4'b1111);
    applyStimulus(1, 2'b01, 1, 1, 4'b1111);
    checkOutput("clr_held_q", 32'(q_out), 32'h0);
    clr = 1'b1;

    // Parallel load 1011.
    applyStimulus(1, 2'b11, 0, 0, 4'b1011);
    checkOutput("load_q",    32'(q_out),     32'hB);
    checkOutput("load_cnt",  32'(shift_cnt), 32'h0);
    checkOutput("load_serr", 32'(ser_out_r), 32'h1);
    checkOutput("load_serl", 32'(ser_out_l), 32'h1);

    // Right frame from 0000 with serial bits 1,0,1,1.
    applyStimulus(1, 2'b11, 0, 0, 4'b0000);
    bitsR = 4'b1101;
    rightQ[0] = 4'b1000; rightQ[1] = 4'b0100; rightQ[2] = 4'b1010; rightQ[3] = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'b01, bitsR[i], 0, 4'b0000);
      checkOutput("rframe_q",    32'(q_out),      32'(rightQ[i]));
      checkOutput("rframe_cnt",  32'(shift_cnt),  32'((i + 1) % 4));
      checkOutput("rframe_done", 32'(frame_done), 32'(i == 3));
    end

    // Direction change: two right, then left restarts the frame.
    applyStimulus(1, 2'b01, 0, 0, 4'b0000);
    applyStimulus(1, 2'b01, 0, 0, 4'b0000);
    checkOutput("dir_cnt2", 32'(shift_cnt), 32'h2);
    applyStimulus(1, 2'b10, 0, 1, 4'b0000);
    checkOutput("dir_cnt1", 32'(shift_cnt),  32'h1);
    checkOutput("dir_lsb",  32'(q_out[0]),   32'h1);
    checkOutput("dir_done", 32'(frame_done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b10, 0, 0, 4'b0000);
      checkOutput("left_done", 32'(frame_done), 32'(i == 2));
    end

    // Enable low blocks a load; hold mid-frame keeps the count.
    applyStimulus(1, 2'b11, 0, 0, 4'b0101);
    applyStimulus(0, 2'b11, 0, 0, 4'b1111);
    checkOutput("en0_q", 32'(q_out), 32'h5);
    applyStimulus(1, 2'b01, 1, 0, 4'b0000);
    applyStimulus(1, 2'b01, 1, 0, 4'b0000);
    applyStimulus(1, 2'b00, 0, 0, 4'b0000);
    checkOutput("hold_cnt", 32'(shift_cnt), 32'h2);
    applyStimulus(1, 2'b01, 0, 0, 4'b0000);
    applyStimulus(1, 2'b01, 0, 0, 4'b0000);
    checkOutput("hold_done", 32'(frame_done), 32'h1);

    // Unknown mode holds state and never corrupts outputs.
    applyStimulus(1, 2'b11, 0, 0, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'bxx, 0, 0, 4'b0110);
      checkOutput("xmode_q",    32'(q_out),      32'h6);
      checkOutput("xmode_done", 32'(frame_done), 32'h0);
      checkOutput("xmode_known", 32'($isunknown({q_out, ser_out_r, ser_out_l, shift_cnt, frame_done})), 32'h0);
    end

    // Continuous right stream: pulses every fourth cycle, no gap.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 2'b01, 1'($urandom_range(0, 1)), 0, 4'b0000);
      checkOutput("stream_done", 32'(frame_done), 32'((i % 4) == 0));
    end

    // Randomized traffic with occasional mid-cycle clears.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        asyncClear();
        applyStimulus(1, 2'($urandom_range(0, 3)), 1, 1, 4'($urandom));
        clr = 1'b1;
      end
    end

    cmpOn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
